seq_event_capture: RTL and testbench
====================================

# seq_event_capture

Downstream capture stage for the serial sequence detector. Edge-detects the detector's `sequence_detected` flag and tags each event with a sequence number and an optional cycle timestamp. Events are buffered in a small first-word-fall-through FIFO, which a consumer drains over a valid/ready handshake. The block also keeps a saturating event count and a sticky overflow flag for status readout.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SEQ_WIDTH, 8: sequence-number and event-count width.
- TS_WIDTH, 16: timestamp width.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- detect_in  in  1  `sequence_detected` from the detector.
- clear  in  1  synchronous clear of FIFO and status.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_seq  out  SEQ_WIDTH  head sequence number.
- evt_ts  out  TS_WIDTH  head timestamp.
- evt_count  out  SEQ_WIDTH  events written to FIFO, saturating.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set when an event is dropped.

## Operation
- **Edge detect:** `detect_d <= detect_in`; `event = detect_in & ~detect_d`.
  - A level held high for several cycles yields one event.
  - `detect_d` resets to 0, so `detect_in` high in the first cycle after reset counts as an event.
- **Timestamp counter:** `ts_cnt` is free-running and increments every cycle, wrapping from all-ones to 0. An entry's timestamp is the `ts_cnt` value in the cycle where `event` is true.
- **Sequence counter:** `seq_cnt` increments on every event, whether stored or dropped, and wraps. The stored value is the pre-increment value, so gaps in `evt_seq` expose drops.
- **Push/pop:**
  - pop = `evt_valid & evt_ready`.
  - push = `event & (!full | pop)`.
  - If full, an event and a pop in the same cycle both succeed and `level` is unchanged.
  - If full with no pop, the event is dropped, `overflow` is set to 1, `level` and `evt_count` are unchanged, and `seq_cnt` still increments.
- **Pointers:** read/write pointers wrap modulo DEPTH. Full/empty is derived from `level`.
- **Count:** `evt_count` increments on each push and saturates at 2^SEQ_WIDTH−1.
- **Head outputs:**
  - `evt_valid = (level != 0)`.
  - `evt_seq` and `evt_ts` show the head entry when valid and are driven 0 when empty.
  - `evt_ready` while `evt_valid` is low has no effect.
- **Clear:** `clear` has priority over push and pop in the same cycle. It sets:
  - `level = 0` and pointers to 0
  - `overflow = 0`
  - `evt_count = 0`
  - `seq_cnt = 0`

  `ts_cnt` and `detect_d` are not affected. An event in the clear cycle is discarded without setting overflow.
- **Reset:** async; all registers go to 0. Outputs during reset: `evt_valid`, `evt_seq`, `evt_ts`, `evt_count`, `level`, `overflow` all 0. Reset mid-transfer discards FIFO contents.

## Timing
- `detect_in` rising in cycle N gives an entry written at the end of N.
  - If the FIFO was empty, `evt_valid` is high in N+1 (1-cycle latency).
  - The entry has `evt_ts = ts_cnt@N`.
- A pop in cycle M advances the head at the end of M. The next entry, if any, is visible in M+1, so back-to-back pops at 1 entry/cycle are supported.
- `level`, `overflow`, and `evt_count` are registered and update on the cycle after the causing event.
- There is no combinational path from `evt_ready` to `evt_valid`, `evt_seq`, or `evt_ts`.

## Configuration
- `SEQ_EVENT_TS_EN` defined:
  - `ts_cnt` exists.
  - The FIFO stores TS_WIDTH timestamp bits per entry.
  - `evt_ts` carries the head timestamp.
- Not defined:
  - No timestamp counter or storage.
  - `evt_ts` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Single event:** reset, then pulse `detect_in` for 1 cycle at `ts_cnt`=10 with `evt_ready`=0. Required: `evt_valid`=1 next cycle, `evt_seq`=0, `evt_ts`=10 (macro on) or 0 (macro off), `level`=1, `evt_count`=1.
- **Held level:** hold `detect_in` high for 5 cycles. Required: exactly one entry and `evt_count`=1.
- **Overflow:** DEPTH=4, 6 separated pulses, `evt_ready`=0. Required: `level`=4, `overflow`=1, `evt_count`=4, `evt_seq` of head=0. Draining yields seq 0,1,2,3; the next event gets seq 6.
- **Full + simultaneous push/pop:** with the FIFO full, pulse `detect_in` while `evt_ready`=1. Required: `level` stays 4, `overflow` stays 0, and the new entry is at the tail.
- **Clear vs. event:** assert `clear` and `detect_in` rising in the same cycle with `level`=3. Required next cycle: `level`=0, `evt_valid`=0, `overflow`=0, `evt_count`=0; the next event gets seq 0.
- **Async reset mid-drain:** assert `reset` asynchronously while popping. Required: all outputs 0 immediately, and the FIFO is empty after release.

Source files
------------

// File: rtl/seq_event_capture.sv
// Event capture stage: edge-detects sequence_detected, tags each event with a sequence number
// (plus a cycle timestamp when SEQ_EVENT_TS_EN is defined) and buffers it in a first-word-fall-through FIFO.
module seq_event_capture #(
  parameter int DEPTH     = 4,
  parameter int SEQ_WIDTH = 8,
  parameter int TS_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   detect_in,
  input  logic                   clear,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [SEQ_WIDTH-1:0]   evt_seq,
  output logic [TS_WIDTH-1:0]    evt_ts,
  output logic [SEQ_WIDTH-1:0]   evt_count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic                 detect_d;
  logic                 evt_pulse;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 wr_en;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [SEQ_WIDTH-1:0] seq_cnt;
  logic [SEQ_WIDTH-1:0] seq_mem [DEPTH];

  assign evt_pulse = detect_in & ~detect_d;
  assign full      = (level == LW'(DEPTH));
  assign evt_valid = (level != '0);
  assign pop       = evt_valid & evt_ready;
  // When full, a same-cycle pop frees the slot the new event takes.
  assign push      = evt_pulse & (~full | pop);
  assign wr_en     = push & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      detect_d  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      seq_cnt   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      detect_d <= detect_in;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        seq_cnt   <= '0;
        evt_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
        // Dropped events still consume a sequence number so gaps reveal the loss.
        if (evt_pulse)          seq_cnt   <= seq_cnt + SEQ_WIDTH'(1);
        if (evt_pulse && !push) overflow  <= 1'b1;
        if (push && evt_count != '1) evt_count <= evt_count + SEQ_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) seq_mem[i] <= '0;
    end else if (wr_en) begin
      seq_mem[wr_ptr] <= seq_cnt;
    end
  end

  assign evt_seq = evt_valid ? seq_mem[rd_ptr] : '0;

`ifdef SEQ_EVENT_TS_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (wr_en) ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign evt_ts = evt_valid ? ts_mem[rd_ptr] : '0;
`else
  assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_seq_event_capture.sv
// Scoreboard bench for seq_event_capture: a queue-based reference model pushes expected entries,
// and a negedge monitor compares head/status outputs and retires entries on each handshake.
module tb_seq_event_capture;
  localparam int DEPTH = 4;
  localparam int SW    = 8;
  localparam int TW    = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   detect_in = 1'b0;
  logic                   clear = 1'b0;
  logic                   evt_ready = 1'b0;
  logic                   evt_valid;
  logic                   overflow;
  logic [SW-1:0]          evt_seq;
  logic [SW-1:0]          evt_count;
  logic [TW-1:0]          evt_ts;
  logic [$clog2(DEPTH):0] level;

  seq_event_capture #(.DEPTH(DEPTH), .SEQ_WIDTH(SW), .TS_WIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .detect_in (detect_in),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_seq   (evt_seq),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] seq;
    logic [TW-1:0] ts;
  } ent_t;

  ent_t          exp_q[$];
  int            mlevel = 0;
  logic          movf = 1'b0;
  logic [SW-1:0] mcount = '0;
  logic [SW-1:0] mseq = '0;
  logic [TW-1:0] ts_m = '0;
  logic          prev_det = 1'b0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is just a count plus the queue of expected entries.
  initial begin
    bit ev, mpop, mpush;
    logic [TW-1:0] ts_exp;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mlevel = 0; exp_q.delete(); movf = 1'b0; mcount = '0;
        mseq = '0; ts_m = '0; prev_det = 1'b0;
      end else begin
        ev = detect_in && !prev_det;
        prev_det = detect_in;
`ifdef SEQ_EVENT_TS_EN
        ts_exp = ts_m;
`else
        ts_exp = '0;
`endif
        if (clear) begin
          mlevel = 0; exp_q.delete(); movf = 1'b0; mcount = '0; mseq = '0;
        end else begin
          mpop  = (mlevel > 0) && evt_ready;
          mpush = ev && ((mlevel < DEPTH) || mpop);
          if (mpush) begin
            exp_q.push_back('{seq: mseq, ts: ts_exp});
            if (mcount != 8'hFF) mcount = mcount + 8'd1;
          end
          if (ev && !mpush) movf = 1'b1;
          if (ev) mseq = mseq + 8'd1;
          mlevel = mlevel + int'(mpush) - int'(mpop);
        end
        ts_m = ts_m + 16'd1;
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("level", 32'(level), 32'(mlevel));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("evt_count", 32'(evt_count), 32'(mcount));
        chk("evt_valid", 32'(evt_valid), 32'(mlevel != 0));
        if (evt_valid) begin
          chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            chk("evt_seq", 32'(evt_seq), 32'(exp_q[0].seq));
            chk("evt_ts", 32'(evt_ts), 32'(exp_q[0].ts));
            if (evt_ready) begin
              $display("pop seq=%0d ts=%0d level=%0d", evt_seq, evt_ts, level);
              void'(exp_q.pop_front());
            end
          end
        end else begin
          chk("empty_seq", 32'(evt_seq), 32'd0);
          chk("empty_ts", 32'(evt_ts), 32'd0);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    detect_in = 1'b1; step(1);
    detect_in = 1'b0; step(1);
  endtask

  task automatic do_clear();
    clear = 1'b1; step(1);
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_seq"}, 32'(evt_seq), 32'd0);
    chk({tag, "_ts"}, 32'(evt_ts), 32'd0);
    chk({tag, "_count"}, 32'(evt_count), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_ts10;
`ifdef SEQ_EVENT_TS_EN
    exp_ts10 = 32'd10;
`else
    exp_ts10 = 32'd0;
`endif
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single event sampled while ts_cnt = 10
    step(10);
    detect_in = 1'b1; step(1); detect_in = 1'b0;
    chk("single_valid", 32'(evt_valid), 32'd1);
    chk("single_seq", 32'(evt_seq), 32'd0);
    chk("single_ts", 32'(evt_ts), exp_ts10);
    chk("single_level", 32'(level), 32'd1);
    chk("single_count", 32'(evt_count), 32'd1);

    // Held level yields one event
    do_clear();
    detect_in = 1'b1; step(5); detect_in = 1'b0; step(1);
    chk("held_level", 32'(level), 32'd1);
    chk("held_count", 32'(evt_count), 32'd1);

    // Overflow with no consumer
    do_clear();
    for (int i = 0; i < 6; i++) pulse();
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(evt_count), 32'd4);
    chk("ovf_head", 32'(evt_seq), 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_seq", 32'(evt_seq), 32'(i));
      step(1);
    end
    evt_ready = 1'b0;
    chk("ovf_drained", 32'(level), 32'd0);
    detect_in = 1'b1; step(1); detect_in = 1'b0;
    chk("ovf_next_seq", 32'(evt_seq), 32'd6);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 4; i++) pulse();
    evt_ready = 1'b1; detect_in = 1'b1; step(1);
    evt_ready = 1'b0; detect_in = 1'b0;
    chk("full_pp_level", 32'(level), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(evt_seq), 32'd1);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_pp_drain", 32'(evt_seq), 32'(i + 1));
      step(1);
    end
    evt_ready = 1'b0;

    // Clear beats a same-cycle event
    do_clear();
    for (int i = 0; i < 3; i++) pulse();
    chk("pre_clear_level", 32'(level), 32'd3);
    clear = 1'b1; detect_in = 1'b1; step(1);
    clear = 1'b0; detect_in = 1'b0;
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_valid", 32'(evt_valid), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_count", 32'(evt_count), 32'd0);
    step(1);
    detect_in = 1'b1; step(1); detect_in = 1'b0;
    chk("clr_next_seq", 32'(evt_seq), 32'd0);

    // Randomised traffic, checked by the monitor
    for (int i = 0; i < 1500; i++) begin
      detect_in = ($urandom_range(0, 99) < 40);
      evt_ready = ($urandom_range(0, 99) < 50);
      clear     = ($urandom_range(0, 99) < 2);
      step(1);
    end
    detect_in = 1'b0; evt_ready = 1'b0; clear = 1'b0;

    // Event count saturation
    do_clear();
    evt_ready = 1'b1;
    for (int i = 0; i < 260; i++) pulse();
    chk("count_sat", 32'(evt_count), 32'd255);
    evt_ready = 1'b0;

    // Asynchronous reset in the middle of a drain
    do_clear();
    for (int i = 0; i < 3; i++) pulse();
    evt_ready = 1'b1; step(1);
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    evt_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    step(2);
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_valid", 32'(evt_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
